// File: rtl/hazard_unit.sv
// Stall, flush and forwarding control for the five-stage RV32I pipeline.
// Also tracks data-memory waits with a watchdog and stall/flush counters.
module hazard_unit #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic [1:0]       ResultSrcE,
  input  logic             PCSrcE,
  input  logic             MemAccessM,
  input  logic             DmemReadyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             WaitState,
  output logic             MemTimeout,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;
  localparam logic [7:0] TO   = 8'(TIMEOUT);

  logic [0:0] state;
  logic [7:0] WaitCnt;
  logic [7:0] waitNext;
  logic       memStall;
  logic       lwStall;
  logic       fwdMA;
  logic       fwdWA;
  logic       fwdMB;
  logic       fwdWB;

  assign memStall = MemAccessM & ~DmemReadyM;
  assign lwStall  = (ResultSrcE == 2'b01) & (RdE != 5'd0)
                  & ((RdE == Rs1D) | (RdE == Rs2D));

  assign fwdMA = RegWriteM & (RdM != 5'd0) & (RdM == Rs1E);
  assign fwdWA = RegWriteW & (RdW != 5'd0) & (RdW == Rs1E);
  assign fwdMB = RegWriteM & (RdM != 5'd0) & (RdM == Rs2E);
  assign fwdWB = RegWriteW & (RdW != 5'd0) & (RdW == Rs2E);

  // A held memory stage freezes everything; E is frozen so branches wait.
  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (!rst) begin
      if (memStall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else begin
        StallF = lwStall;
        StallD = lwStall;
        FlushD = PCSrcE;
        FlushE = lwStall | PCSrcE;
      end
      unique case (1'b1)
        fwdMA:          ForwardAE = 2'b10;
        fwdWA & ~fwdMA: ForwardAE = 2'b01;
        default:        ForwardAE = 2'b00;
      endcase
      unique case (1'b1)
        fwdMB:          ForwardBE = 2'b10;
        fwdWB & ~fwdMB: ForwardBE = 2'b01;
        default:        ForwardBE = 2'b00;
      endcase
    end
  end

  assign waitNext  = (WaitCnt >= TO) ? TO : WaitCnt + 8'd1;
  assign WaitState = (state == WAIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      WaitCnt    <= 8'd0;
      MemTimeout <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (memStall) begin
            state   <= WAIT;
            WaitCnt <= 8'd1;
          end
        end
        default: begin
          if (memStall) begin
            WaitCnt <= waitNext;
            if (waitNext == TO) MemTimeout <= 1'b1;
          end else begin
            state   <= RUN;
            WaitCnt <= 8'd0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (StallF && (StallCount != '1))
        StallCount <= StallCount + CNT_W'(1);
      if (FlushE && (FlushCount != '1))
        FlushCount <= FlushCount + CNT_W'(1);
    end
  end

endmodule
